// File: rtl/motor_fifo_player.sv
// Drains 40-bit motion FIFO entries into step/dir/enable activity on CHANNELS stepper drivers.
// Optional endstop gating of STEP commands is compiled in with MOTOR_FIFO_PLAYER_ENDSTOP_EN.
module motor_fifo_player #(
    parameter int unsigned CHANNELS          = 12,
    parameter int unsigned STEP_PULSE_CYCLES = 50,
    parameter int unsigned DIR_SETUP_CYCLES  = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                abort,
    input  logic                clear_error,
    input  logic                fifo_empty,
    output logic                fifo_read,
    input  logic [39:0]         fifo_data,
    output logic [CHANNELS-1:0] mot_step,
    output logic [CHANNELS-1:0] mot_dir,
    output logic [CHANNELS-1:0] mot_enable,
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
    input  logic [CHANNELS-1:0] endstop,
    output logic [CHANNELS-1:0] endstop_hit,
`endif
    output logic                busy,
    output logic                error,
    output logic [31:0]         cmd_count
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ARG_W = 32;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_NOP        = 8'h00;
    localparam logic [OP_W-1:0] OP_SET_DIR    = 8'h01;
    localparam logic [OP_W-1:0] OP_SET_ENABLE = 8'h02;
    localparam logic [OP_W-1:0] OP_STEP       = 8'h03;
    localparam logic [OP_W-1:0] OP_DELAY      = 8'h04;
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
    localparam logic [OP_W-1:0] OP_SET_ES_MASK = 8'h05;
`endif

    // Counter loads are "cycles - 1": the counter reaches zero in the last cycle of the phase.
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(STEP_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIR_LOAD    = CNT_W'(DIR_SETUP_CYCLES - 1);
    localparam bit               DIR_WAIT_EN = (DIR_SETUP_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PULSE_HI,
        S_PULSE_LO,
        S_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [39:0]           cmd_q, cmd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CHANNELS-1:0]   mot_step_q, mot_step_d;
    logic [CHANNELS-1:0]   mot_dir_q, mot_dir_d;
    logic [CHANNELS-1:0]   mot_enable_q, mot_enable_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic [31:0]           cmd_count_q, cmd_count_d;

    logic [OP_W-1:0]       opcode;
    logic [ARG_W-1:0]      arg;
    logic [CHANNELS-1:0]   mask;
    logic [CHANNELS-1:0]   blocked;
    logic                  op_valid;

    assign opcode = cmd_q[39:32];
    assign arg    = cmd_q[ARG_W-1:0];
    assign mask   = cmd_q[CHANNELS-1:0];

`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
    logic [CHANNELS-1:0] es_mask_q, es_mask_d;
    logic [CHANNELS-1:0] es_hit_q, es_hit_d;

    assign blocked     = endstop & es_mask_q;
    assign endstop_hit = es_hit_q;
    assign op_valid    = (opcode <= OP_SET_ES_MASK);
`else
    assign blocked  = '0;
    assign op_valid = (opcode <= OP_DELAY);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (run && !fifo_empty) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_STEP:    state_d = S_PULSE_HI;
                    OP_SET_DIR: state_d = (DIR_WAIT_EN && (mask != mot_dir_q)) ? S_WAIT : S_IDLE;
                    OP_DELAY:   state_d = (arg != '0) ? S_WAIT : S_IDLE;
                    default:    state_d = S_IDLE;
                endcase
            end
            S_PULSE_HI: if (cnt_q == '0) state_d = S_PULSE_LO;
            S_PULSE_LO: if (cnt_q == '0) state_d = S_IDLE;
            S_WAIT:     if (cnt_q == '0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Datapath and output next values.
    always_comb begin
        fifo_read    = (state_q == S_IDLE) && (state_d == S_FETCH);
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        mot_step_d   = (state_d == S_PULSE_HI) ? mot_step_q : '0;
        mot_dir_d    = mot_dir_q;
        mot_enable_d = mot_enable_q;
        busy_d       = (state_d != S_IDLE);
        error_d      = error_q & ~clear_error;
        cmd_count_d  = cmd_count_q;
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
        es_mask_d    = es_mask_q;
        es_hit_d     = es_hit_q & ~{CHANNELS{clear_error}};
`endif

        if (state_q == S_FETCH) cmd_d = fifo_data;

        if (state_d != state_q) begin
            case (state_d)
                S_PULSE_HI, S_PULSE_LO: cnt_d = PULSE_LOAD;
                S_WAIT:                 cnt_d = (opcode == OP_DELAY) ? arg - 32'd1 : DIR_LOAD;
                default:                cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
        end

        // An aborted decode leaves no trace: no output change, no count, no error.
        if ((state_q == S_DECODE) && !abort) begin
            case (opcode)
                OP_SET_DIR:    mot_dir_d    = mask;
                OP_SET_ENABLE: mot_enable_d = ~mask;
                OP_STEP: begin
                    mot_step_d = mask & ~blocked;
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
                    es_hit_d   = es_hit_d | blocked;
`endif
                end
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
                OP_SET_ES_MASK: es_mask_d = mask;
`endif
                default: ;
            endcase
            if (op_valid) begin
                cmd_count_d = cmd_count_q + 32'd1;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            cnt_q        <= '0;
            mot_step_q   <= '0;
            mot_dir_q    <= '0;
            mot_enable_q <= '1;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            cmd_count_q  <= '0;
        end else begin
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            mot_step_q   <= mot_step_d;
            mot_dir_q    <= mot_dir_d;
            mot_enable_q <= mot_enable_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es_mask_q <= '0;
            es_hit_q  <= '0;
        end else begin
            es_mask_q <= es_mask_d;
            es_hit_q  <= es_hit_d;
        end
    end
`endif

    assign mot_step   = mot_step_q;
    assign mot_dir    = mot_dir_q;
    assign mot_enable = mot_enable_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_motor_fifo_player.sv
// Self-checking bench for motor_fifo_player: directed table, corner sequences, random timeline model.
module tb_motor_fifo_player;

    localparam int unsigned CH = 12;
    localparam int unsigned P  = 4;
    localparam int unsigned D  = 3;
    localparam int MAXC = 512;
    localparam int NRND = 25;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          abort;
    logic          clear_error;
    logic          fifo_empty;
    logic          fifo_read;
    logic [39:0]   fifo_data;
    logic [CH-1:0] mot_step;
    logic [CH-1:0] mot_dir;
    logic [CH-1:0] mot_enable;
    logic          busy;
    logic          error;
    logic [31:0]   cmd_count;
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
    logic [CH-1:0] endstop;
    logic [CH-1:0] endstop_hit;
`endif

    motor_fifo_player #(
        .CHANNELS(CH),
        .STEP_PULSE_CYCLES(P),
        .DIR_SETUP_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .abort(abort),
        .clear_error(clear_error),
        .fifo_empty(fifo_empty),
        .fifo_read(fifo_read),
        .fifo_data(fifo_data),
        .mot_step(mot_step),
        .mot_dir(mot_dir),
        .mot_enable(mot_enable),
`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
        .endstop(endstop),
        .endstop_hit(endstop_hit),
`endif
        .busy(busy),
        .error(error),
        .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: data appears the cycle after a read strobe.
    logic [39:0] mem [0:255];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] arg);
        mem[wr_ptr] = {op, arg};
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Raise run and wait (bounded) for the read strobe; returns sampled in the read cycle.
    task automatic launch();
        int k;
        @(negedge clk); run = 1'b1; #1;
        k = 0;
        while (!fifo_read && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        chk("fetch_seen", 64'(fifo_read), 64'd1);
    endtask

    task automatic start_cmd(input logic [7:0] op, input logic [31:0] arg);
        push(op, arg);
        launch();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; abort = 1'b0; clear_error = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]    op;
        logic [31:0]   arg;
        logic [CH-1:0] e_dir;
        logic [CH-1:0] e_en;
        logic [CH-1:0] e_step;
        logic [31:0]   e_cnt;
        logic          e_err;
        int            e_busy;
        int            e_hi;
    } vec_t;

    vec_t tbl [11];

    // Random-run timeline model, indexed by cycle offset from the first read.
    logic [7:0]    rop  [NRND];
    logic [31:0]   rarg [NRND];
    logic          e_read [MAXC];
    logic          e_busy [MAXC];
    logic [CH-1:0] e_step [MAXC];
    logic [CH-1:0] e_dir  [MAXC];
    logic [CH-1:0] e_en   [MAXC];
    logic [31:0]   e_cnt  [MAXC];
    logic          e_err  [MAXC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nb, nhi, c, nr, t, dur, total;
        bit done, valid;
        logic [CH-1:0] m_dir, m_en, msk;
        logic [31:0] m_cnt;
        logic m_err;

`ifdef MOTOR_FIFO_PLAYER_ENDSTOP_EN
        endstop = '0;
`endif
        tbl[0]  = '{8'h02, 32'h0000_0FFF, 12'h000, 12'h000, 12'h000, 32'd1,  1'b0, 2,  0};
        tbl[1]  = '{8'h01, 32'h0000_0005, 12'h005, 12'h000, 12'h000, 32'd2,  1'b0, 5,  0};
        tbl[2]  = '{8'h03, 32'h0000_000F, 12'h005, 12'h000, 12'h00F, 32'd3,  1'b0, 10, 4};
        tbl[3]  = '{8'h01, 32'h0000_0005, 12'h005, 12'h000, 12'h000, 32'd4,  1'b0, 2,  0};
        tbl[4]  = '{8'h04, 32'h0000_0000, 12'h005, 12'h000, 12'h000, 32'd5,  1'b0, 2,  0};
        tbl[5]  = '{8'h04, 32'h0000_000A, 12'h005, 12'h000, 12'h000, 32'd6,  1'b0, 12, 0};
        tbl[6]  = '{8'h00, 32'hDEAD_BEEF, 12'h005, 12'h000, 12'h000, 32'd7,  1'b0, 2,  0};
        tbl[7]  = '{8'h7F, 32'h0000_0000, 12'h005, 12'h000, 12'h000, 32'd7,  1'b1, 2,  0};
        tbl[8]  = '{8'h02, 32'hFFFF_F0F0, 12'h005, 12'hF0F, 12'h000, 32'd8,  1'b1, 2,  0};
        tbl[9]  = '{8'h01, 32'h0000_FABC, 12'hABC, 12'hF0F, 12'h000, 32'd9,  1'b1, 5,  0};
        tbl[10] = '{8'h03, 32'hFFFF_F801, 12'hABC, 12'hF0F, 12'h801, 32'd10, 1'b1, 10, 4};

        do_reset();
        chk("rst_step", 64'(mot_step), 64'd0);
        chk("rst_dir", 64'(mot_dir), 64'd0);
        chk("rst_enable", 64'(mot_enable), 64'hFFF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_count", 64'(cmd_count), 64'd0);
        chk("rst_read", 64'(fifo_read), 64'd0);

        // Directed table: one command at a time from idle.
        for (int i = 0; i < 11; i++) begin
            start_cmd(tbl[i].op, tbl[i].arg);
            nb = 0; nhi = 0; c = 1; done = 1'b0;
            while (!done && c < 200) begin
                @(negedge clk); run = 1'b0; #1;
                if (c == 3) begin
                    chk($sformatf("tbl%0d_dir", i), 64'(mot_dir), 64'(tbl[i].e_dir));
                    chk($sformatf("tbl%0d_enable", i), 64'(mot_enable), 64'(tbl[i].e_en));
                    chk($sformatf("tbl%0d_step", i), 64'(mot_step), 64'(tbl[i].e_step));
                    chk($sformatf("tbl%0d_count", i), 64'(cmd_count), 64'(tbl[i].e_cnt));
                    chk($sformatf("tbl%0d_error", i), 64'(error), 64'(tbl[i].e_err));
                end
                if (mot_step != '0) nhi++;
                if (busy) nb++;
                else done = 1'b1;
                c++;
            end
            chk($sformatf("tbl%0d_busy_cycles", i), 64'(nb), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_step_cycles", i), 64'(nhi), 64'(tbl[i].e_hi));
        end

        // Unknown opcode decoded together with clear_error: set wins.
        start_cmd(8'h7F, 32'h0);
        @(negedge clk); run = 1'b0; #1;
        @(negedge clk); clear_error = 1'b1; #1;
        @(negedge clk); clear_error = 1'b0; #1;
        chk("err_set_wins", 64'(error), 64'd1);
        chk("err_not_counted", 64'(cmd_count), 64'd10);
        @(negedge clk); clear_error = 1'b1; #1;
        @(negedge clk); clear_error = 1'b0; #1;
        chk("err_cleared", 64'(error), 64'd0);

        // Abort in the second PULSE_HI cycle.
        start_cmd(8'h03, 32'h0000_00F0);
        @(negedge clk); run = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("abort_pre_step", 64'(mot_step), 64'h0F0);
        @(negedge clk); abort = 1'b1; #1;
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_step", 64'(mot_step), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dir", 64'(mot_dir), 64'hABC);
        chk("abort_enable", 64'(mot_enable), 64'hF0F);
        chk("abort_count", 64'(cmd_count), 64'd11);
        push(8'h00, 32'h0);
        nr = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (fifo_read) nr++;
        end
        chk("no_fetch_run_low", 64'(nr), 64'd0);
        launch();
        repeat (3) begin @(negedge clk); run = 1'b0; #1; end
        chk("drain_count", 64'(cmd_count), 64'd12);

        // Abort during DECODE discards the entry.
        start_cmd(8'h01, 32'h0000_0111);
        @(negedge clk); run = 1'b0; #1;
        @(negedge clk); abort = 1'b1; #1;
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_dec_dir", 64'(mot_dir), 64'hABC);
        chk("abort_dec_count", 64'(cmd_count), 64'd12);
        chk("abort_dec_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a pulse.
        start_cmd(8'h03, 32'h0000_000F);
        @(negedge clk); run = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("arst_pre_step", 64'(mot_step), 64'h00F);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_step", 64'(mot_step), 64'd0);
        chk("arst_enable", 64'(mot_enable), 64'hFFF);
        chk("arst_count", 64'(cmd_count), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;

        // Random command stream against a timeline model.
        for (int i = 0; i < NRND; i++) begin
            case ($urandom_range(0, 9))
                0, 9:    begin rop[i] = 8'h00; rarg[i] = $urandom; end
                1, 2:    begin
                    rop[i] = 8'h01;
                    rarg[i] = $urandom;
                    case ($urandom_range(0, 3))
                        0: rarg[i][11:0] = 12'h000;
                        1: rarg[i][11:0] = 12'h00F;
                        2: rarg[i][11:0] = 12'hF00;
                        default: ;
                    endcase
                end
                3:       begin rop[i] = 8'h02; rarg[i] = $urandom; end
                4, 5:    begin rop[i] = 8'h03; rarg[i] = $urandom; end
                6, 7:    begin rop[i] = 8'h04; rarg[i] = 32'($urandom_range(0, 12)); end
                default: begin rop[i] = 8'($urandom_range(6, 255)); rarg[i] = $urandom; end
            endcase
        end

        m_dir = '0; m_en = '1; m_cnt = '0; m_err = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            e_read[k] = 1'b0; e_busy[k] = 1'b0; e_step[k] = '0;
            e_dir[k] = '0; e_en[k] = '1; e_cnt[k] = '0; e_err[k] = 1'b0;
        end
        t = 0;
        for (int i = 0; i < NRND; i++) begin
            msk = rarg[i][CH-1:0];
            dur = 3;
            valid = 1'b1;
            case (rop[i])
                8'h00: ;
                8'h01: begin
                    if (msk != m_dir) dur += D;
                    m_dir = msk;
                end
                8'h02: m_en = ~msk;
                8'h03: begin
                    dur += 2 * P;
                    for (int k = 0; k < P; k++) e_step[t + 3 + k] = msk;
                end
                8'h04: dur += int'(rarg[i]);
                default: begin valid = 1'b0; m_err = 1'b1; end
            endcase
            if (valid) m_cnt = m_cnt + 32'd1;
            e_read[t] = 1'b1;
            for (int k = 1; k < dur; k++) e_busy[t + k] = 1'b1;
            for (int k = t + 3; k < MAXC; k++) begin
                e_dir[k] = m_dir; e_en[k] = m_en; e_cnt[k] = m_cnt; e_err[k] = m_err;
            end
            t += dur;
        end
        total = t + 4;
        if (total > MAXC) total = MAXC;

        for (int i = 0; i < NRND; i++) push(rop[i], rarg[i]);
        @(negedge clk); run = 1'b1; #1;
        for (int cyc = 0; cyc < total; cyc++) begin
            chk($sformatf("rnd%0d_read", cyc), 64'(fifo_read), 64'(e_read[cyc]));
            chk($sformatf("rnd%0d_busy", cyc), 64'(busy), 64'(e_busy[cyc]));
            chk($sformatf("rnd%0d_step", cyc), 64'(mot_step), 64'(e_step[cyc]));
            chk($sformatf("rnd%0d_dir", cyc), 64'(mot_dir), 64'(e_dir[cyc]));
            chk($sformatf("rnd%0d_enable", cyc), 64'(mot_enable), 64'(e_en[cyc]));
            chk($sformatf("rnd%0d_count", cyc), 64'(cmd_count), 64'(e_cnt[cyc]));
            chk($sformatf("rnd%0d_error", cyc), 64'(error), 64'(e_err[cyc]));
            @(negedge clk); #1;
        end
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
